// File: rtl/frame_symbol_sequencer.sv
// frame_symbol_sequencer: serialises a parallel payload word into 10-bit tagged
// symbols (comma, SOP, payload bytes MSB first, optional CRC-8, EOP, gap commas).
// The symbol position is tracked internally. One symbol advances per sym_adv strobe.
// Optional feature: define FRAME_CRC_EN to insert a CRC-8 byte (poly 0x07, init 0)
// between the last payload byte and EOP.
module frame_symbol_sequencer #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int IDLE_COMMAS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*PAYLOAD_BYTES-1:0] data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  input  logic [7:0]                 Kchar_sop,
  input  logic [7:0]                 Kchar_eop,
  input  logic [7:0]                 Kchar_comma,
  input  logic                       sym_adv,
  output logic [9:0]                 sym_out,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int CW    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int NSLOT = 2 ** CW;
  localparam logic [CW-1:0] LAST_BYTE = CW'(PAYLOAD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_DATA,
`ifdef FRAME_CRC_EN
    S_CRC,
`endif
    S_EOP,
    S_GAP
  } state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              byte_cnt_q, byte_cnt_d;
  logic [3:0]                 gap_cnt_q, gap_cnt_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic                       frame_done_q, frame_done_d;
  logic [7:0]                 pay_bytes [NSLOT];
  logic [7:0]                 cur_byte;

`ifdef FRAME_CRC_EN
  logic [7:0] crc_q, crc_d;

  // Byte-wise CRC-8, polynomial x^8+x^2+x+1, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
    logic [7:0] c;
    c = crc_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`endif

  // Slice the latched payload into bytes; slot 0 is the first byte on the wire.
  // Slots beyond the payload (power-of-two padding) read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_bytes
      if (gi < PAYLOAD_BYTES) begin : g_used
        assign pay_bytes[gi] = payload_q[8*(PAYLOAD_BYTES-gi)-1 -: 8];
      end else begin : g_pad
        assign pay_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign cur_byte   = pay_bytes[byte_cnt_q];
  // Ready is masked while reset is held so nothing is accepted during reset.
  assign data_ready = rst && (state_q == S_IDLE);
  assign frame_done = frame_done_q;

  // Next-state, counter and payload-latch logic; every path holds unless sym_adv.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    payload_d    = payload_q;
    frame_done_d = 1'b0;
`ifdef FRAME_CRC_EN
    crc_d        = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (data_valid && data_ready) begin
          payload_d  = data_in;
          byte_cnt_d = '0;
`ifdef FRAME_CRC_EN
          crc_d      = 8'h00;
`endif
          state_d    = S_SOP;
        end
      end
      S_SOP: begin
        if (sym_adv) state_d = S_DATA;
      end
      S_DATA: begin
        if (sym_adv) begin
`ifdef FRAME_CRC_EN
          crc_d = crc8_byte(crc_q, cur_byte);
`endif
          if (byte_cnt_q == LAST_BYTE) begin
`ifdef FRAME_CRC_EN
            state_d = S_CRC;
`else
            state_d = S_EOP;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
`ifdef FRAME_CRC_EN
      S_CRC: begin
        if (sym_adv) state_d = S_EOP;
      end
`endif
      S_EOP: begin
        if (sym_adv) begin
          frame_done_d = 1'b1;
          if (IDLE_COMMAS == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = 4'(IDLE_COMMAS);
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (sym_adv) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
          if (gap_cnt_q == 4'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= 4'd0;
      payload_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef FRAME_CRC_EN
      crc_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      payload_q    <= payload_d;
      frame_done_q <= frame_done_d;
`ifdef FRAME_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  // Symbol and busy decode from registered state only.
  always_comb begin
    sym_out = {2'b11, Kchar_comma};
    busy    = 1'b0;
    case (state_q)
      S_SOP: begin
        sym_out = {2'b10, Kchar_sop};
        busy    = 1'b1;
      end
      S_DATA: begin
        sym_out = {2'b00, cur_byte};
        busy    = 1'b1;
      end
`ifdef FRAME_CRC_EN
      S_CRC: begin
        sym_out = {2'b00, crc_q};
        busy    = 1'b1;
      end
`endif
      S_EOP: begin
        sym_out = {2'b01, Kchar_eop};
        busy    = 1'b1;
      end
      default: begin
        sym_out = {2'b11, Kchar_comma};
        busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_symbol_sequencer.sv
// Directed testbench for frame_symbol_sequencer. Instance a: 4 bytes, 1 gap comma;
// instance b: 4 bytes, no gap commas; instance c (FRAME_CRC_EN only): 1 byte.
module tb_frame_symbol_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid;
  logic        sym_adv;
  logic [7:0]  k_sop, k_eop, k_comma;

  logic       rdy_a, busy_a, done_a;
  logic [9:0] sym_a;
  logic       rdy_b, busy_b, done_b;
  logic [9:0] sym_b;
`ifdef FRAME_CRC_EN
  logic [7:0] din_c;
  logic       rdy_c, busy_c, done_c;
  logic [9:0] sym_c;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] sym;
    logic       done;
    logic       rdy;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  frame_symbol_sequencer #(.PAYLOAD_BYTES(4), .IDLE_COMMAS(1)) u_dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_a),
    .Kchar_sop(k_sop), .Kchar_eop(k_eop), .Kchar_comma(k_comma), .sym_adv(sym_adv),
    .sym_out(sym_a), .busy(busy_a), .frame_done(done_a));

  frame_symbol_sequencer #(.PAYLOAD_BYTES(4), .IDLE_COMMAS(0)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(rdy_b),
    .Kchar_sop(k_sop), .Kchar_eop(k_eop), .Kchar_comma(k_comma), .sym_adv(sym_adv),
    .sym_out(sym_b), .busy(busy_b), .frame_done(done_b));

`ifdef FRAME_CRC_EN
  frame_symbol_sequencer #(.PAYLOAD_BYTES(1), .IDLE_COMMAS(0)) u_dut_c (
    .clk(clk), .rst(rst), .data_in(din_c), .data_valid(data_valid), .data_ready(rdy_c),
    .Kchar_sop(k_sop), .Kchar_eop(k_eop), .Kchar_comma(k_comma), .sym_adv(sym_adv),
    .sym_out(sym_c), .busy(busy_c), .frame_done(done_c));

  // Bit-serial reference CRC-8 (poly 0x07) over the top pb bytes of d.
  function automatic logic [7:0] ref_crc(input logic [31:0] d, input int pb);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 8*pb-1; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction
`endif

  function automatic logic [9:0] sym_of(input int sel);
    case (sel)
      1:       return sym_b;
`ifdef FRAME_CRC_EN
      2:       return sym_c;
`endif
      default: return sym_a;
    endcase
  endfunction

  function automatic logic [2:0] flags_of(input int sel);
    case (sel)
      1:       return {done_b, rdy_b, busy_b};
`ifdef FRAME_CRC_EN
      2:       return {done_c, rdy_c, busy_c};
`endif
      default: return {done_a, rdy_a, busy_a};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [9:0] s, input logic d, input logic r);
    exp_t e;
    e.sym  = s;
    e.done = d;
    e.rdy  = r;
    exp_q.push_back(e);
  endtask

  // Expected symbols from SOP through the IDLE comma that follows the frame.
  task automatic build(input logic [31:0] d, input int pb, input int ic);
    logic [31:0] sh;
    push(10'h23C, 1'b0, 1'b0);
    for (int i = 0; i < pb; i++) begin
      sh = d >> (8 * (pb - 1 - i));
      push({2'b00, sh[7:0]}, 1'b0, 1'b0);
    end
`ifdef FRAME_CRC_EN
    push({2'b00, ref_crc(d, pb)}, 1'b0, 1'b0);
`endif
    push(10'h1DC, 1'b0, 1'b0);
    for (int i = 0; i < ic; i++) push(10'h3BC, (i == 0), 1'b0);
    push(10'h3BC, (ic == 0), 1'b1);
  endtask

  task automatic run(input string tag, input int sel, input int from, input int to);
    logic [2:0] f;
    for (int k = from; k <= to; k++) begin
      f = flags_of(sel);
      check($sformatf("%s_sym%0d", tag, k), 32'(sym_of(sel)), 32'(exp_q[k].sym));
      check($sformatf("%s_done%0d", tag, k), 32'(f[2]), 32'(exp_q[k].done));
      check($sformatf("%s_rdy%0d", tag, k), 32'(f[1]), 32'(exp_q[k].rdy));
      check($sformatf("%s_busy%0d", tag, k), 32'(f[0]), 32'(exp_q[k].sym[9:8] != 2'b11));
      $display("step %s[%0d] sym=%h done=%b rdy=%b busy=%b", tag, k, sym_of(sel), f[2], f[1], f[0]);
      if (k < to) tick();
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    data_valid = 1'b0;
    sym_adv    = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic accept(input logic [31:0] d);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    k_comma = 8'hBC;
    k_sop   = 8'h3C;
    k_eop   = 8'hDC;
    rst        = 1'b0;
    data_valid = 1'b0;
    sym_adv    = 1'b1;
    data_in    = 32'h0;
`ifdef FRAME_CRC_EN
    din_c = 8'h00;
`endif

    // Reset state
    tick();
    tick();
    check("reset_sym", 32'(sym_a), 32'h3BC);
    check("reset_ready", 32'(rdy_a), 32'h0);
    check("reset_busy", 32'(busy_a), 32'h0);
    check("reset_done", 32'(done_a), 32'h0);
    rst = 1'b1;
    #1;
    check("release_ready", 32'(rdy_a), 32'h1);
    check("idle_sym", 32'(sym_a), 32'h3BC);

    // Basic frame, sym_adv high
    accept(32'hDEADBEEF);
    exp_q.delete();
    build(32'hDEADBEEF, 4, 1);
    run("basic", 0, 0, exp_q.size() - 1);

    // Back-pressure: hold on 0xAD for 5 cycles with a competing payload offered
    do_reset();
    accept(32'hDEADBEEF);
    exp_q.delete();
    build(32'hDEADBEEF, 4, 1);
    run("bp", 0, 0, 2);
    sym_adv    = 1'b0;
    data_valid = 1'b1;
    data_in    = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_hold_sym%0d", i), 32'(sym_a), 32'h0AD);
      check($sformatf("bp_hold_rdy%0d", i), 32'(rdy_a), 32'h0);
      $display("step bp_hold[%0d] sym=%h rdy=%b", i, sym_a, rdy_a);
    end
    sym_adv = 1'b1;
    tick();
    run("bp", 0, 3, exp_q.size() - 1);
    data_valid = 1'b0;

    // Back-to-back, no gap commas: period 7 (8 with CRC)
    do_reset();
    data_in    = 32'hDEADBEEF;
    data_valid = 1'b1;
    tick();
    exp_q.delete();
    build(32'hDEADBEEF, 4, 0);
    build(32'hDEADBEEF, 4, 0);
    run("b2b", 1, 0, exp_q.size() - 1);
    data_valid = 1'b0;

`ifdef FRAME_CRC_EN
    // CRC frames on the single-byte instance
    do_reset();
    din_c      = 8'h01;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    exp_q.delete();
    push(10'h23C, 1'b0, 1'b0);
    push(10'h001, 1'b0, 1'b0);
    push(10'h007, 1'b0, 1'b0);
    push(10'h1DC, 1'b0, 1'b0);
    push(10'h3BC, 1'b1, 1'b1);
    run("crc01", 2, 0, 4);
    din_c      = 8'h00;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    exp_q.delete();
    push(10'h23C, 1'b0, 1'b0);
    push(10'h000, 1'b0, 1'b0);
    push(10'h000, 1'b0, 1'b0);
    push(10'h1DC, 1'b0, 1'b0);
    push(10'h3BC, 1'b1, 1'b1);
    run("crc00", 2, 0, 4);
`endif

    // Reset mid-frame while showing 0xBE
    do_reset();
    accept(32'hDEADBEEF);
    tick();
    tick();
    tick();
    check("mid_pre_sym", 32'(sym_a), 32'h0BE);
    rst = 1'b0;
    tick();
    check("mid_rst_sym", 32'(sym_a), 32'h3BC);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    check("mid_rst_done", 32'(done_a), 32'h0);
    check("mid_rst_ready", 32'(rdy_a), 32'h0);
    rst = 1'b1;
    #1;
    check("mid_release_ready", 32'(rdy_a), 32'h1);
    $display("step mid_reset sym=%h busy=%b rdy=%b", sym_a, busy_a, rdy_a);
    accept(32'h11223344);
    exp_q.delete();
    build(32'h11223344, 4, 1);
    run("restart", 0, 0, exp_q.size() - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_symbol_sequencer.md
# frame_symbol_sequencer

Parametrised frame sequencer that turns a parallel payload word into a stream of 10-bit tagged symbols: comma, SOP, payload bytes (MSB first), optional CRC byte, EOP. It tracks its own symbol position internally instead of taking an external address. It accepts payloads through a valid/ready handshake and advances one symbol per downstream `sym_adv` strobe. It sits between the MOPSHUB receive-data path and the SPI/elink symbol transmitter.

## Interface
- `PAYLOAD_BYTES`, 4, payload bytes per frame; legal range 1..16.
- `IDLE_COMMAS`, 1, extra comma symbols forced after each EOP; legal range 0..15.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `data_in`  input  8*PAYLOAD_BYTES  payload; byte `[8*PAYLOAD_BYTES-1 -: 8]` is sent first.
- `data_valid`  input  1  payload offered.
- `data_ready`  output  1  block can accept a payload.
- `Kchar_sop`, `Kchar_eop`, `Kchar_comma`  input  8 each  K-character codes; sampled live, not latched.
- `sym_adv`  input  1  downstream consumed the current `sym_out` at this edge.
- `sym_out`  output  10  current symbol.
- `busy`  output  1  high in SOP, DATA, CRC and EOP.
- `frame_done`  output  1  one-cycle pulse after EOP is consumed.

## Operation
- Symbol encoding:
  - comma = {2'b11, Kchar_comma}
  - SOP = {2'b10, Kchar_sop}
  - data/CRC = {2'b00, byte}
  - EOP = {2'b01, Kchar_eop}
- FSM states: IDLE, SOP, DATA, CRC (only with the CRC macro defined), EOP, GAP.
- `sym_out` is a combinational decode of registered state, byte counter and latched payload.
- IDLE:
  - `sym_out` = comma; `data_ready` = 1.
  - On `data_valid && data_ready`: latch `data_in`, clear the byte counter, go to SOP. `sym_adv` is ignored in IDLE.
- SOP: on `sym_adv`, go to DATA.
- DATA:
  - `sym_out` = payload byte indexed by `byte_cnt`, MSB byte at count 0.
  - On `sym_adv`, if `byte_cnt == PAYLOAD_BYTES-1`, go to CRC (macro defined) or EOP. Otherwise increment `byte_cnt`.
- CRC: emits the CRC byte; on `sym_adv`, go to EOP.
- EOP:
  - On `sym_adv`, pulse `frame_done` for the next cycle.
  - If `IDLE_COMMAS == 0`, go to IDLE. Otherwise load `gap_cnt = IDLE_COMMAS` and go to GAP.
- GAP:
  - `sym_out` = comma; `data_ready` = 0.
  - On `sym_adv`, decrement `gap_cnt`; when it reaches 1 at an `sym_adv` edge, go to IDLE.
- Counter widths:
  - `byte_cnt` is `$clog2(PAYLOAD_BYTES)` bits, minimum 1.
  - `gap_cnt` is 4 bits.
  - Neither counter wraps; both are bounded by the FSM.
- `data_ready` is 0 in every state except IDLE. A payload offered mid-frame is held off, never dropped or overwritten. The latched payload is stable for the whole frame.
- `sym_adv` low: state, counters and `sym_out` hold indefinitely.
- Comma count between frames: at least `IDLE_COMMAS + 1` comma symbols, counting the IDLE cycle.

## Timing
- Reset, when `rst` = 0 at an edge:
  - state = IDLE, `sym_out` = comma, `data_ready` = 0 during reset and 1 on the first cycle after release.
  - `busy` = 0, `frame_done` = 0, counters = 0, latched payload = 0.
- Reset mid-frame aborts immediately: no EOP is emitted, and the next cycle shows comma.
- Accept to SOP on `sym_out`: 1 cycle.
- With `sym_adv` tied high:
  - SOP, then `PAYLOAD_BYTES` data symbols, then optional CRC, then EOP, then `IDLE_COMMAS` GAP commas, then IDLE.
  - Back-to-back frame period = `PAYLOAD_BYTES + 3 + IDLE_COMMAS` cycles, plus 1 with the CRC macro defined.
- `frame_done` is asserted in the cycle after the EOP-consuming edge, coincident with the first GAP or IDLE cycle.

## Configuration
- `FRAME_CRC_EN` defined:
  - CRC state is present. One CRC-8 byte (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) is computed over the payload bytes and emitted between the last data symbol and EOP.
  - The CRC is accumulated as each data symbol is consumed and cleared on accept and on reset.
- Not defined: no CRC logic or state; DATA goes directly to EOP.

## Test plan
- Common setup for all scenarios: `Kchar_comma` = 0xBC, `Kchar_sop` = 0x3C, `Kchar_eop` = 0xDC.
- Basic frame: `PAYLOAD_BYTES` = 4, `IDLE_COMMAS` = 1, no CRC, `sym_adv` = 1, `data_in` = 0xDEADBEEF offered once -> `sym_out` 0x3BC, 0x23C, 0x0DE, 0x0AD, 0x0BE, 0x0EF, 0x1DC, 0x3BC, 0x3BC. `frame_done` pulses in the cycle of the first 0x3BC after EOP.
- Back-pressure: same frame with `sym_adv` low for 5 cycles while showing 0x0AD -> 0x0AD held 5 cycles, then the sequence resumes unchanged. `data_ready` stays 0 throughout, even with `data_valid` high and a new `data_in`.
- Back-to-back with `IDLE_COMMAS` = 0: `data_valid` held high -> exactly one 0x3BC between 0x1DC and the next 0x23C; period 7 cycles.
- CRC with `FRAME_CRC_EN`: `PAYLOAD_BYTES` = 1, `data_in` = 0x01 -> 0x23C, 0x001, 0x007, 0x1DC. With `data_in` = 0x00, the CRC symbol is 0x000.
- Reset mid-frame: `rst` = 0 for one edge while showing 0x0BE -> next cycle `sym_out` = 0x3BC and `busy` = 0. The cycle after release has `data_ready` = 1, and a new frame starts cleanly with SOP.
